// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multi-cycle RV32I control FSM with memory-wait timeout; optional mul/div via CTRL_MULDIV_EN
module ctrl_fsm #(
  parameter int TIMEOUT   = 15,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 bit20,
  input  logic                 bit25,
  input  logic                 bit30,
  input  logic                 cmp_out,
  input  logic                 mem_ready,
  input  logic                 md_done,
  output logic [2:0]           state,
  output logic                 halt,
  output logic                 trap,
  output logic                 pc_enable,
  output logic                 pc_load,
  output logic                 reg_re,
  output logic                 reg_we,
  output logic                 target_load,
  output logic                 inst_load,
  output logic                 alu_sel1,
  output logic                 alu_sel2,
  output logic [4:0]           alu_op,
  output logic [1:0]           wd_sel,
  output logic                 mem_valid,
  output logic                 mem_addr_sel,
  output logic [2:0]           mem_read_op,
  output logic [1:0]           mem_write_op,
  output logic                 md_start,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] state_next;
  logic [7:0] wait_cnt;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic is_op_imm, is_op, is_fence, is_system, is_valid, is_md;
  logic mem_wait, timed_out;

  assign is_lui    = (opcode == 7'b0110111);
  assign is_auipc  = (opcode == 7'b0010111);
  assign is_jal    = (opcode == 7'b1101111);
  assign is_jalr   = (opcode == 7'b1100111);
  assign is_branch = (opcode == 7'b1100011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_op_imm = (opcode == 7'b0010011);
  assign is_op     = (opcode == 7'b0110011);
  assign is_fence  = (opcode == 7'b0001111);
  assign is_system = (opcode == 7'b1110011);
  assign is_valid  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                     is_store | is_op_imm | is_op | is_fence | is_system;

`ifdef CTRL_MULDIV_EN
  logic md_busy;
  assign is_md    = is_op & bit25;
  assign md_start = (state == S_EXEC) & is_md & ~md_busy;
`else
  logic unused_md;
  assign is_md     = 1'b0;
  assign md_start  = 1'b0;
  assign unused_md = md_done ^ bit25;
`endif

  // The wait counter only moves in FETCH/MEM; every other state parks it at zero.
  assign mem_wait  = (state == S_FETCH) | (state == S_MEM);
  assign timed_out = mem_wait & ~mem_ready & (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      instret  <= '0;
`ifdef CTRL_MULDIV_EN
      md_busy  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      wait_cnt <= (mem_wait & ~mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      if (state == S_WB)
        instret <= instret + INSTRET_W'(1);
`ifdef CTRL_MULDIV_EN
      md_busy  <= (state == S_EXEC) & (state_next == S_EXEC);
`endif
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (timed_out) state_next = S_TRAP;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_system & bit20)          state_next = S_HALT;
        else if (!is_valid)             state_next = S_TRAP;
        else if (is_md & ~md_done)      state_next = S_EXEC;
        else if (is_load | is_store)    state_next = S_MEM;
        else                            state_next = S_WB;
      end
      S_MEM:    if (mem_ready) state_next = S_WB;
                else if (timed_out) state_next = S_TRAP;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_TRAP;
    endcase
  end

  always_comb begin
    halt         = 1'b0;
    trap         = 1'b0;
    pc_enable    = 1'b0;
    pc_load      = 1'b0;
    reg_re       = 1'b0;
    reg_we       = 1'b0;
    target_load  = 1'b0;
    inst_load    = 1'b0;
    alu_sel1     = 1'b0;
    alu_sel2     = 1'b0;
    alu_op       = 5'd0;
    mem_valid    = 1'b0;
    mem_addr_sel = 1'b0;
    mem_read_op  = 3'b011;
    mem_write_op = 2'b11;
    wd_sel       = is_md ? 2'b10 : (is_jal | is_jalr) ? 2'b01 : is_load ? 2'b11 : 2'b00;
    case (state)
      S_FETCH: begin
        mem_valid   = 1'b1;
        mem_read_op = 3'b010;
        inst_load   = mem_ready;
      end
      S_DECODE: begin
        reg_re      = 1'b1;
        target_load = 1'b1;
        alu_sel1    = 1'b1;
        alu_sel2    = 1'b1;
      end
      S_EXEC: begin
        alu_sel2    = is_load | is_store | is_jalr;
        target_load = is_jalr;
      end
      S_MEM: begin
        mem_valid    = 1'b1;
        mem_addr_sel = 1'b1;
        if (is_load)  mem_read_op  = funct3;
        if (is_store) mem_write_op = funct3[1:0];
      end
      S_WB: begin
        pc_enable = 1'b1;
        pc_load   = is_jal | is_jalr | (is_branch & cmp_out);
        reg_we    = is_op_imm | is_lui | is_auipc | is_op | is_jal | is_jalr | is_load;
        alu_sel1  = is_auipc;
        alu_sel2  = is_auipc | is_op_imm | is_lui;
        if (is_op | (is_op_imm & (funct3 == 3'b101))) alu_op = {1'b0, bit30, funct3};
        else if (is_op_imm)                          alu_op = {2'b00, funct3};
        else if (is_branch)                          alu_op = {2'b10, funct3};
      end
      S_HALT:  halt = 1'b1;
      default: trap = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - directed self-checking bench for ctrl_fsm (TIMEOUT=4)
module tb_ctrl_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        bit20, bit25, bit30, cmp_out, mem_ready, md_done;
  logic [2:0]  state;
  logic        halt, trap, pc_enable, pc_load, reg_re, reg_we, target_load, inst_load;
  logic        alu_sel1, alu_sel2, mem_valid, mem_addr_sel, md_start;
  logic [4:0]  alu_op;
  logic [1:0]  wd_sel, mem_write_op;
  logic [2:0]  mem_read_op;
  logic [31:0] instret;
  int checks = 0;
  int errors = 0;

  ctrl_fsm #(.TIMEOUT(4), .INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .bit20(bit20),
    .bit25(bit25), .bit30(bit30), .cmp_out(cmp_out), .mem_ready(mem_ready),
    .md_done(md_done), .state(state), .halt(halt), .trap(trap), .pc_enable(pc_enable),
    .pc_load(pc_load), .reg_re(reg_re), .reg_we(reg_we), .target_load(target_load),
    .inst_load(inst_load), .alu_sel1(alu_sel1), .alu_sel2(alu_sel2), .alu_op(alu_op),
    .wd_sel(wd_sel), .mem_valid(mem_valid), .mem_addr_sel(mem_addr_sel),
    .mem_read_op(mem_read_op), .mem_write_op(mem_write_op), .md_start(md_start),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [6:0] op, input logic [2:0] f3,
                          input logic b20, input logic b25, input logic b30);
    opcode = op; funct3 = f3; bit20 = b20; bit25 = b25; bit30 = b30;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; md_done = 1'b0; cmp_out = 1'b0;
    set_inst(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); step();
    // reset state
    check("rst_state", state, 3'd0);
    check("rst_mem_valid", mem_valid, 1'b1);
    check("rst_instret", instret, 32'd0);
    check("rst_halt_trap", {halt, trap}, 2'b00);
    check("rst_strobes", {pc_enable, pc_load, reg_re, reg_we, target_load, inst_load}, 6'd0);
    check("rst_read_op", mem_read_op, 3'b010);
    check("rst_write_op", mem_write_op, 2'b11);

    // ADDI, mem_ready always high
    reset = 1'b0; mem_ready = 1'b1; #1;
    check("addi_inst_load", inst_load, 1'b1);
    step();
    check("addi_decode", state, 3'd1);
    check("addi_decode_out", {reg_re, target_load, alu_sel1, alu_sel2, mem_valid}, 5'b11110);
    step();
    check("addi_exec", state, 3'd2);
    step();
    check("addi_wb", state, 3'd4);
    check("addi_wb_out", {pc_enable, pc_load, reg_we, alu_sel1, alu_sel2}, 5'b10101);
    check("addi_alu_op", alu_op, 5'b00000);
    check("addi_instret_wb", instret, 32'd0);
    step();
    check("addi_fetch", state, 3'd0);
    check("addi_instret", instret, 32'd1);

    // LW with three not-ready cycles in MEM
    set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    step(); step();
    check("lw_exec_sel", {alu_sel1, alu_sel2}, 2'b01);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_held", state, 3'd3);
      check("lw_mem_out", {mem_valid, mem_addr_sel, mem_read_op, mem_write_op}, 7'b1101011);
      step();
    end
    check("lw_mem_4th", state, 3'd3);
    mem_ready = 1'b1;
    step();
    check("lw_wb", state, 3'd4);
    check("lw_wb_out", {wd_sel, reg_we, trap, mem_read_op}, 7'b1110011);
    step();
    check("lw_instret", instret, 32'd2);

    // BEQ taken then not taken
    set_inst(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
    cmp_out = 1'b1;
    step(); step(); step();
    check("beq_t_wb", {state, pc_enable, pc_load, reg_we}, 6'b100110);
    check("beq_t_alu_op", alu_op, 5'b10000);
    step();
    cmp_out = 1'b0;
    step(); step(); step();
    check("beq_nt_wb", {state, pc_enable, pc_load, reg_we}, 6'b100100);
    step();

    // SB: store op in MEM, no register write
    set_inst(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    check("sb_mem", {state, mem_read_op, mem_write_op}, 8'b01101100);
    step();
    check("sb_wb", {state, reg_we, wd_sel}, 6'b100000);
    step();
    check("sb_instret", instret, 32'd5);

    // SUB: alu_op carries bit30
    set_inst(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    check("sub_alu_op", alu_op, 5'b01000);
    step();

    // OP with bit25 set
    set_inst(7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0);
    step(); step();
`ifdef CTRL_MULDIV_EN
    for (int i = 1; i <= 5; i++) begin
      check("mul_exec_held", state, 3'd2);
      check("mul_md_start", md_start, (i == 1));
      step();
    end
    md_done = 1'b1;
    check("mul_exec_6th", {state, md_start}, 4'b0100);
    step();
    md_done = 1'b0;
    check("mul_wb", {state, wd_sel, reg_we}, 6'b100101);
`else
    check("mul_plain_exec", {state, md_start}, 4'b0100);
    step();
    check("mul_plain_wb", {state, wd_sel, reg_we}, 6'b100001);
`endif
    step();
    check("mul_instret", instret, 32'd7);

    // EBREAK halts, sticky
    set_inst(7'b1110011, 3'b000, 1'b1, 1'b0, 1'b0);
    step();
    check("ebreak_dec_pc", pc_enable, 1'b0);
    step();
    check("ebreak_exec_pc", pc_enable, 1'b0);
    step();
    check("ebreak_halt", {state, halt, trap, pc_enable, mem_valid}, 7'b1011000);
    step(); step();
    check("ebreak_sticky", {state, halt, pc_enable, mem_valid, reg_we}, 7'b1011000);
    check("halt_read_op", {mem_read_op, mem_write_op}, 5'b01111);
    do_reset();
    check("halt_reset", {state, instret}, {3'd0, 32'd0});

    // Illegal opcode traps
    set_inst(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    check("illegal_trap", {state, trap, halt, pc_enable}, 6'b110100);
    do_reset();

    // FETCH timeout: four not-ready cycles then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_fetch_wait", state, 3'd0);
    end
    step();
    check("to_trap", {state, trap}, 4'b1101);
    mem_ready = 1'b1;
    step(); step();
    check("to_trap_sticky", {state, trap, mem_valid}, 5'b11010);
    do_reset();
    check("to_reset", {state, trap, instret}, {3'd0, 1'b0, 32'd0});

    // Ready arriving on the final allowed cycle wins over the timeout
    mem_ready = 1'b0;
    step(); step(); step();
    mem_ready = 1'b1;
    step();
    check("to_ready_wins", state, 3'd1);

    // Reset while stalled in MEM
    set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    step(); step();
    mem_ready = 1'b0;
    step();
    check("midmem_state", state, 3'd3);
    do_reset();
    check("midmem_reset", {state, mem_valid, mem_addr_sel}, 5'b00010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
